// File: rtl/jzjpcc_hazard_control.sv
// Front-end stall/flush scheduler: load-use bubbles, control-transfer squash,
// debug halt handshake with back-end drain, and a saturating stall-cycle counter.
module jzjpcc_hazard_control #(
    parameter int DRAIN_CYCLES  = 3,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pcCTWriteEnable_decode,
    input  logic                     loadUseHazard,
    input  logic                     halt_request,
    output logic                     pcCTWriteEnable,
    output logic                     stall_fetch,
    output logic                     stall_decode,
    output logic                     flush_decode,
    output logic                     flush_execute,
    output logic                     halt_ack,
    output logic [COUNTER_WIDTH-1:0] stallCount
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTING = 2'd1,
        HALTED  = 2'd2
    } state_t;

    localparam logic [3:0]               DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    state_t                   r_state;
    state_t                   w_state_next;
    logic [3:0]               r_drain_cnt;
    logic [3:0]               w_drain_cnt_next;
    logic [COUNTER_WIDTH-1:0] r_stall_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= RUN;
            r_drain_cnt   <= '0;
            r_stall_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
            if (stall_fetch && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + COUNT_ONE;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        pcCTWriteEnable  = 1'b0;
        stall_fetch      = 1'b0;
        stall_decode     = 1'b0;
        flush_decode     = 1'b0;
        flush_execute    = 1'b0;
        halt_ack         = 1'b0;

        case (r_state)
            RUN: begin
                // Load-use wins over a control transfer: a branch/jalr reading
                // the loaded value must wait until the operand is available.
                if (loadUseHazard) begin
                    stall_fetch   = 1'b1;
                    stall_decode  = 1'b1;
                    flush_execute = 1'b1;
                end else if (pcCTWriteEnable_decode) begin
                    pcCTWriteEnable = 1'b1;
                    flush_decode    = 1'b1;
                end
                if (halt_request) begin
                    w_state_next     = HALTING;
                    w_drain_cnt_next = '0;
                end
            end
            HALTING: begin
                stall_fetch      = 1'b1;
                stall_decode     = 1'b1;
                flush_execute    = 1'b1;
                w_drain_cnt_next = r_drain_cnt + 4'd1;
                // The drain always completes; the request is only consulted at the end.
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_next = halt_request ? HALTED : RUN;
                end
            end
            HALTED: begin
                stall_fetch   = 1'b1;
                stall_decode  = 1'b1;
                flush_execute = 1'b1;
                halt_ack      = 1'b1;
                if (!halt_request) begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase

        if (reset) begin
            pcCTWriteEnable = 1'b0;
            stall_fetch     = 1'b0;
            stall_decode    = 1'b0;
            flush_decode    = 1'b0;
            flush_execute   = 1'b0;
            halt_ack        = 1'b0;
        end
    end

    assign stallCount = r_stall_count;

endmodule

// File: tb/tb_jzjpcc_hazard_control.sv
// Directed bench for jzjpcc_hazard_control: expected outputs are queued as each
// step is driven and compared at the following falling edge.
module tb_jzjpcc_hazard_control;

    localparam int DRAIN = 3;

    logic        clock;
    logic        reset;
    logic        pcCTWriteEnable_decode;
    logic        loadUseHazard;
    logic        halt_request;
    logic        pcCTWriteEnable;
    logic        stall_fetch;
    logic        stall_decode;
    logic        flush_decode;
    logic        flush_execute;
    logic        halt_ack;
    logic [31:0] stallCount;

    logic        pc4, sf4, sd4, fd4, fe4, ack4;
    logic [3:0]  stallCount4;

    jzjpcc_hazard_control #(.DRAIN_CYCLES(DRAIN), .COUNTER_WIDTH(32)) u_dut (
        .clock                  (clock),
        .reset                  (reset),
        .pcCTWriteEnable_decode (pcCTWriteEnable_decode),
        .loadUseHazard          (loadUseHazard),
        .halt_request           (halt_request),
        .pcCTWriteEnable        (pcCTWriteEnable),
        .stall_fetch            (stall_fetch),
        .stall_decode           (stall_decode),
        .flush_decode           (flush_decode),
        .flush_execute          (flush_execute),
        .halt_ack               (halt_ack),
        .stallCount             (stallCount)
    );

    jzjpcc_hazard_control #(.DRAIN_CYCLES(DRAIN), .COUNTER_WIDTH(4)) u_dut4 (
        .clock                  (clock),
        .reset                  (reset),
        .pcCTWriteEnable_decode (pcCTWriteEnable_decode),
        .loadUseHazard          (loadUseHazard),
        .halt_request           (halt_request),
        .pcCTWriteEnable        (pc4),
        .stall_fetch            (sf4),
        .stall_decode           (sd4),
        .flush_decode           (fd4),
        .flush_execute          (fe4),
        .halt_ack               (ack4),
        .stallCount             (stallCount4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        pc;
        logic        sf;
        logic        sd;
        logic        fd;
        logic        fe;
        logic        ack;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int step_no     = 0;

    // Reference model: 0 = running, 1 = draining, 2 = halted
    int          m_state = 0;
    int          m_drain = 0;
    logic [31:0] m_cnt   = 0;
    logic [3:0]  m_cnt4  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, expv);
        end
    endtask

    function automatic exp_t predict(input logic rst, input logic lu, input logic ct);
        exp_t e;
        e      = '0;
        e.cnt  = m_cnt;
        e.cnt4 = m_cnt4;
        if (!rst) begin
            if (m_state == 0) begin
                if (lu) begin
                    e.sf = 1'b1; e.sd = 1'b1; e.fe = 1'b1;
                end else begin
                    e.pc = ct; e.fd = ct;
                end
            end else begin
                e.sf = 1'b1; e.sd = 1'b1; e.fe = 1'b1;
                e.ack = (m_state == 2);
            end
        end
        return e;
    endfunction

    // Entered just after a rising edge; returns just after the next one.
    task automatic apply(input logic rst, input logic lu, input logic ct, input logic hr);
        exp_t e;
        exp_t got;
        reset                  = rst;
        loadUseHazard          = lu;
        pcCTWriteEnable_decode = ct;
        halt_request           = hr;
        exp_q.push_back(predict(rst, lu, ct));
        @(negedge clock);
        got = exp_q.pop_front();
        chk("pcCTWriteEnable", {31'd0, pcCTWriteEnable}, {31'd0, got.pc});
        chk("stall_fetch",     {31'd0, stall_fetch},     {31'd0, got.sf});
        chk("stall_decode",    {31'd0, stall_decode},    {31'd0, got.sd});
        chk("flush_decode",    {31'd0, flush_decode},    {31'd0, got.fd});
        chk("flush_execute",   {31'd0, flush_execute},   {31'd0, got.fe});
        chk("halt_ack",        {31'd0, halt_ack},        {31'd0, got.ack});
        chk("stallCount",      stallCount,               got.cnt);
        chk("stallCount_w4",   {28'd0, stallCount4},     {28'd0, got.cnt4});
        $display("step %0d rst=%b lu=%b ct=%b hr=%b -> pc=%b sf=%b fd=%b fe=%b ack=%b cnt=%0d cnt4=%0d",
                 step_no, rst, lu, ct, hr, pcCTWriteEnable, stall_fetch, flush_decode,
                 flush_execute, halt_ack, stallCount, stallCount4);
        e = got;
        @(posedge clock);
        if (rst) begin
            m_state = 0; m_drain = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            if (e.sf) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
            end
            case (m_state)
                0: if (hr) begin m_state = 1; m_drain = 0; end
                1: begin
                    if (m_drain == DRAIN - 1) m_state = hr ? 2 : 0;
                    else m_drain = m_drain + 1;
                end
                default: if (!hr) m_state = 0;
            endcase
        end
        step_no++;
        #1;
    endtask

    initial begin
        reset = 1'b1; loadUseHazard = 1'b0; pcCTWriteEnable_decode = 1'b0; halt_request = 1'b0;
        @(posedge clock);
        #1;

        // Reset, then idle
        apply(1, 0, 0, 0);
        apply(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 0);

        // Two-cycle load-use hazard
        apply(0, 1, 0, 0);
        apply(0, 1, 0, 0);
        apply(0, 0, 0, 0);
        chk("cnt_after_loaduse", stallCount, 32'd2);

        // Hazard beats control transfer, then the transfer goes through
        apply(0, 1, 1, 0);
        apply(0, 0, 1, 0);
        apply(0, 0, 0, 0);

        // Held halt: 1 run cycle, 3 drain, 2 halted, release cycle, back to run
        for (int i = 0; i < 6; i++) apply(0, 0, 0, 1);
        chk("halt_ack_held", {31'd0, halt_ack}, 32'd1);
        apply(0, 0, 0, 0);
        apply(0, 0, 1, 0);
        chk("cnt_after_halt", stallCount, 32'd9);

        // One-cycle halt pulse: full drain, never acknowledged
        apply(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 0);

        // Reset while halted
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 1);
        apply(1, 0, 0, 1);
        chk("cnt_after_reset", stallCount, 32'd0);
        apply(0, 0, 0, 0);

        // Mixed pseudo-random traffic
        for (int i = 0; i < 24; i++) begin
            apply(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 6; i++) apply(0, 0, 0, 0);

        // Long halt drives the 4-bit counter into saturation
        for (int i = 0; i < 24; i++) apply(0, 0, 0, 1);
        chk("cnt4_saturated", {28'd0, stallCount4}, 32'd15);
        apply(0, 0, 0, 0);
        apply(0, 1, 0, 0);
        apply(0, 0, 0, 0);
        chk("cnt4_held", {28'd0, stallCount4}, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
